// File: rtl/msxbus_burst_bridge.sv
// Host byte-stream to MSX cartridge bus engine: CS-framed command/address/data bytes become timed mem/io cycles.
// Define MSXBUS_BURST_EN to honour the burst flag, the LEN byte and per-beat address auto-increment.
module msxbus_burst_bridge #(
  parameter int SLOTS     = 2,
  parameter int T_SETUP   = 2,
  parameter int T_STROBE  = 6,
  parameter int T_RECOVER = 2,
  parameter int WAIT_MAX  = 1023
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic             HSTB,
  input  logic [7:0]       HDATA,
  output logic [7:0]       ROUT,
  output logic             RVALID,
  output logic             BUSY,
  output logic             ERR,
  input  logic             WAIT_n,
  input  logic [7:0]       DATA_I,
  output logic [7:0]       DATA_O,
  output logic             DATA_OE,
  output logic [15:0]      ADDR,
  output logic             RD_n,
  output logic             WR_n,
  output logic             MREQ_n,
  output logic             IORQ_n,
  output logic [SLOTS-1:0] SLTSL_n
);

  localparam int WW   = $clog2(WAIT_MAX + 1);
  localparam int TMAX = (T_SETUP > T_STROBE) ?
                        ((T_SETUP > T_RECOVER) ? T_SETUP : T_RECOVER) :
                        ((T_STROBE > T_RECOVER) ? T_STROBE : T_RECOVER);
  localparam int PW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_L, S_HDR_H, S_LEN, S_WDATA, S_SETUP, S_STROBE, S_RECOVER
  } state_t;

  state_t state_reg, state_next;

  logic          cs_reg, hstb_reg;
  logic [7:0]    hdata_reg;
  logic          wait_s1_reg, wait_s2_reg;
  logic [1:0]    op_reg;
  logic [2:0]    slot_reg;
  logic [15:0]   addr_reg;
  logic [7:0]    wdata_reg, rdata_reg, rout_reg;
  logic          rd_done_reg, rvalid_reg, err_reg, abort_reg;
  logic [PW-1:0] cnt_reg;
  logic [WW-1:0] wait_cnt_reg;
`ifdef MSXBUS_BURST_EN
  logic          burst_reg;
  logic [8:0]    beats_reg;
`endif

  logic             host_byte, is_write, is_io, phase_last, wait_expired, last_beat;
  logic [SLOTS-1:0] slot_sel;

  assign host_byte    = hstb_reg & ~cs_reg;
  assign is_write     = op_reg[0];
  assign is_io        = op_reg[1];
  assign wait_expired = (wait_cnt_reg == WW'(WAIT_MAX));
`ifdef MSXBUS_BURST_EN
  assign last_beat    = (beats_reg == 9'd1);
`else
  assign last_beat    = 1'b1;
`endif

  // Out-of-range slot numbers match no decoder, leaving every select high (open-bus access).
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign slot_sel[gi] = ~(slot_reg == 3'(gi));
  end

  always_comb begin
    phase_last = 1'b0;
    case (state_reg)
      S_SETUP:   phase_last = (cnt_reg == PW'(T_SETUP - 1));
      S_STROBE:  phase_last = (cnt_reg == PW'(T_STROBE - 1));
      S_RECOVER: phase_last = (cnt_reg == PW'(T_RECOVER - 1));
      default:   phase_last = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (host_byte) state_next = S_HDR_L;
      S_HDR_L: if (cs_reg) state_next = S_IDLE;
               else if (hstb_reg) state_next = S_HDR_H;
      S_HDR_H: if (cs_reg) state_next = S_IDLE;
               else if (hstb_reg) begin
                 state_next = is_write ? S_WDATA : S_SETUP;
`ifdef MSXBUS_BURST_EN
                 if (burst_reg) state_next = S_LEN;
`endif
               end
      S_LEN:   if (cs_reg) state_next = S_IDLE;
               else if (hstb_reg) state_next = is_write ? S_WDATA : S_SETUP;
      S_WDATA: if (cs_reg) state_next = S_IDLE;
               else if (hstb_reg) state_next = S_SETUP;
      S_SETUP: if (cs_reg) state_next = S_RECOVER;
               else if (phase_last) state_next = S_STROBE;
      // Strobe ends once the minimum is met and WAIT is released, or the wait budget runs out.
      S_STROBE: if (cs_reg || (phase_last && (wait_s2_reg || wait_expired)))
                  state_next = S_RECOVER;
      S_RECOVER: if (phase_last) begin
                   if (abort_reg || cs_reg || last_beat) state_next = S_IDLE;
                   else state_next = is_write ? S_WDATA : S_SETUP;
                 end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    RD_n    = 1'b1;
    WR_n    = 1'b1;
    MREQ_n  = 1'b1;
    IORQ_n  = 1'b1;
    SLTSL_n = '1;
    DATA_OE = 1'b0;
    if (state_reg == S_SETUP || state_reg == S_STROBE) begin
      MREQ_n  = is_io;
      IORQ_n  = ~is_io;
      SLTSL_n = is_io ? '1 : slot_sel;
      DATA_OE = is_write;
      if (state_reg == S_STROBE) begin
        RD_n = is_write;
        WR_n = ~is_write;
      end
    end
  end

  assign BUSY   = (state_reg != S_IDLE);
  assign ADDR   = addr_reg;
  assign DATA_O = wdata_reg;
  assign ROUT   = rout_reg;
  assign RVALID = rvalid_reg;
  assign ERR    = err_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_reg       <= 1'b1;
      hstb_reg     <= 1'b0;
      hdata_reg    <= '0;
      wait_s1_reg  <= 1'b1;
      wait_s2_reg  <= 1'b1;
      op_reg       <= '0;
      slot_reg     <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      rout_reg     <= '0;
      rd_done_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      err_reg      <= 1'b0;
      abort_reg    <= 1'b0;
      cnt_reg      <= '0;
      wait_cnt_reg <= '0;
`ifdef MSXBUS_BURST_EN
      burst_reg    <= 1'b0;
      beats_reg    <= 9'd1;
`endif
    end else begin
      cs_reg      <= CS;
      hstb_reg    <= HSTB;
      hdata_reg   <= HDATA;
      wait_s1_reg <= WAIT_n;
      wait_s2_reg <= wait_s1_reg;
      rd_done_reg <= 1'b0;
      rvalid_reg  <= rd_done_reg;
      if (rd_done_reg) rout_reg <= rdata_reg;

      if (state_next != state_reg) cnt_reg <= '0;
      else if (!phase_last)        cnt_reg <= cnt_reg + PW'(1);

      if (state_reg != S_STROBE) wait_cnt_reg <= '0;
      else if (phase_last && !wait_s2_reg && !wait_expired)
        wait_cnt_reg <= wait_cnt_reg + WW'(1);

      case (state_reg)
        S_IDLE: begin
          abort_reg <= 1'b0;
          if (host_byte) begin
            op_reg   <= hdata_reg[7:6];
            slot_reg <= hdata_reg[5:3];
            err_reg  <= 1'b0;
`ifdef MSXBUS_BURST_EN
            burst_reg <= hdata_reg[2];
            beats_reg <= 9'd1;
`endif
          end
        end
        S_HDR_L: if (host_byte) addr_reg[7:0]  <= hdata_reg;
        S_HDR_H: if (host_byte) addr_reg[15:8] <= hdata_reg;
`ifdef MSXBUS_BURST_EN
        S_LEN:   if (host_byte) beats_reg <= (hdata_reg == 8'd0) ? 9'd256 : {1'b0, hdata_reg};
`endif
        S_WDATA: if (host_byte) wdata_reg <= hdata_reg;
        S_SETUP: if (cs_reg) abort_reg <= 1'b1;
        S_STROBE: begin
          if (cs_reg) abort_reg <= 1'b1;
          else if (phase_last) begin
            if (wait_s2_reg) begin
              if (!is_write) begin
                rdata_reg   <= DATA_I;
                rd_done_reg <= 1'b1;
              end
            end else if (wait_expired) begin
              err_reg   <= 1'b1;
              abort_reg <= 1'b1;
            end
          end
        end
        S_RECOVER: begin
          if (cs_reg) abort_reg <= 1'b1;
`ifdef MSXBUS_BURST_EN
          // I/O ports live in ADDR[7:0]; the upper byte is held across an I/O burst.
          if (state_next == S_WDATA || state_next == S_SETUP) begin
            beats_reg <= beats_reg - 9'd1;
            addr_reg  <= is_io ? {addr_reg[15:8], addr_reg[7:0] + 8'd1} : addr_reg + 16'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msxbus_burst_bridge.sv
// Directed bench for msxbus_burst_bridge: frames are sent byte by byte and a bus monitor logs each strobe.
module tb_msxbus_burst_bridge;

`ifdef MSXBUS_BURST_EN
  localparam int NB4 = 4;
  localparam int NB3 = 3;
  localparam int NB2 = 2;
`else
  localparam int NB4 = 1;
  localparam int NB3 = 1;
  localparam int NB2 = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST, CS, HSTB, WAIT_n;
  logic [7:0] HDATA, DATA_I;
  logic [7:0] ROUT, DATA_O;
  logic       RVALID, BUSY, ERR, DATA_OE, RD_n, WR_n, MREQ_n, IORQ_n;
  logic [15:0] ADDR;
  logic [1:0] SLTSL_n;

  int n_tests = 0;
  int n_fail  = 0;

  msxbus_burst_bridge dut (
    .CLK(CLK), .RST(RST), .CS(CS), .HSTB(HSTB), .HDATA(HDATA),
    .ROUT(ROUT), .RVALID(RVALID), .BUSY(BUSY), .ERR(ERR),
    .WAIT_n(WAIT_n), .DATA_I(DATA_I), .DATA_O(DATA_O), .DATA_OE(DATA_OE),
    .ADDR(ADDR), .RD_n(RD_n), .WR_n(WR_n), .MREQ_n(MREQ_n), .IORQ_n(IORQ_n),
    .SLTSL_n(SLTSL_n)
  );

  always #5 CLK = ~CLK;

  // Bus monitor, sampled on the falling edge.
  int         cyc = 0;
  logic       mon_clr = 1'b0;
  logic       strobe_prev = 1'b0;
  int         n_strobe = 0, n_rv = 0, cur_len = 0, cur_setup = 0, last_rise = 0;
  logic [15:0] mon_addr [0:7];
  logic [7:0]  mon_do   [0:7];
  logic [7:0]  mon_rout [0:7];
  logic [1:0]  mon_sl   [0:7];
  logic        mon_mreq [0:7];
  logic        mon_iorq [0:7];
  logic        mon_oe   [0:7];
  logic        mon_wr   [0:7];
  int          mon_len  [0:7];
  int          mon_setup[0:7];
  int          mon_start[0:7];
  int          mon_rvdly[0:7];
  logic        mon_strobe, mon_sel;

  assign mon_strobe = !RD_n || !WR_n;
  assign mon_sel    = !MREQ_n || !IORQ_n;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    strobe_prev <= mon_strobe;
    if (mon_sel && !mon_strobe) cur_setup <= cur_setup + 1;
    else if (!mon_sel)          cur_setup <= 0;
    if (mon_strobe && !strobe_prev) begin
      cur_len <= 1;
      if (n_strobe < 8) begin
        mon_addr[n_strobe]  <= ADDR;
        mon_do[n_strobe]    <= DATA_O;
        mon_sl[n_strobe]    <= SLTSL_n;
        mon_mreq[n_strobe]  <= MREQ_n;
        mon_iorq[n_strobe]  <= IORQ_n;
        mon_oe[n_strobe]    <= DATA_OE;
        mon_wr[n_strobe]    <= !WR_n;
        mon_setup[n_strobe] <= cur_setup;
        mon_start[n_strobe] <= cyc;
      end
    end else if (mon_strobe) begin
      cur_len <= cur_len + 1;
    end
    if (!mon_strobe && strobe_prev) begin
      if (n_strobe < 8) mon_len[n_strobe] <= cur_len;
      n_strobe  <= n_strobe + 1;
      last_rise <= cyc;
    end
    if (RVALID) begin
      if (n_rv < 8) begin
        mon_rout[n_rv]  <= ROUT;
        mon_rvdly[n_rv] <= cyc - last_rise;
      end
      n_rv <= n_rv + 1;
    end
    if (mon_clr) begin
      n_strobe <= 0;
      n_rv     <= 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    HSTB  = 1'b1;
    HDATA = b;
    tick();
    HSTB  = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY && n < 3000) begin
      tick();
      n++;
    end
    check_val(tag, BUSY, 1'b0);
  endtask

  task automatic wait_strobe_low(input string tag);
    int n = 0;
    while (RD_n && WR_n && n < 50) begin
      tick();
      n++;
    end
    check_val(tag, (!RD_n || !WR_n), 1'b1);
  endtask

  logic [7:0] wbuf [0:7];

  task automatic do_frame(input logic [7:0] cmd, input logic [15:0] addr,
                          input logic [7:0] len, input int nbeats);
    mon_clear();
    CS = 1'b0;
    send_byte(cmd);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
`ifdef MSXBUS_BURST_EN
    if (cmd[2]) send_byte(len);
`endif
    if (cmd[6]) begin
      for (int i = 0; i < nbeats; i++) begin
        if (i > 0) begin
          int n = 0;
          while (n_strobe < i && n < 200) begin
            tick();
            n++;
          end
          check_val("wdata_beat_wait", (n_strobe >= i), 1'b1);
          tick();
          tick();
        end
        send_byte(wbuf[i]);
      end
    end
    wait_idle("frame_idle");
    CS = 1'b1;
    tick();
    $display("[TB] frame cmd=%02h addr=%04h len=%0d beats=%0d strobes=%0d rvalids=%0d err=%0b",
             cmd, addr, len, nbeats, n_strobe, n_rv, ERR);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; CS = 1'b1; HSTB = 1'b0; HDATA = 8'h00; WAIT_n = 1'b1; DATA_I = 8'h00;
    repeat (3) tick();
    check_val("rst_rd_n",   RD_n,    1'b1);
    check_val("rst_wr_n",   WR_n,    1'b1);
    check_val("rst_mreq_n", MREQ_n,  1'b1);
    check_val("rst_iorq_n", IORQ_n,  1'b1);
    check_val("rst_sltsl",  SLTSL_n, 2'b11);
    check_val("rst_oe",     DATA_OE, 1'b0);
    check_val("rst_do",     DATA_O,  8'h00);
    check_val("rst_addr",   ADDR,    16'h0000);
    check_val("rst_rout",   ROUT,    8'h00);
    check_val("rst_rvalid", RVALID,  1'b0);
    check_val("rst_busy",   BUSY,    1'b0);
    check_val("rst_err",    ERR,     1'b0);
    RST = 1'b0;
    tick();
    $display("[TB] reset released");

    // mem read 0x4034, slot 0
    DATA_I = 8'hAA;
    do_frame(8'h00, 16'h4034, 8'h00, 1);
    check_val("rd_nstrobe", n_strobe,     1);
    check_val("rd_is_rd",   mon_wr[0],    1'b0);
    check_val("rd_len",     mon_len[0],   6);
    check_val("rd_setup",   mon_setup[0], 2);
    check_val("rd_addr",    mon_addr[0],  16'h4034);
    check_val("rd_mreq",    mon_mreq[0],  1'b0);
    check_val("rd_iorq",    mon_iorq[0],  1'b1);
    check_val("rd_sltsl",   mon_sl[0],    2'b10);
    check_val("rd_oe",      mon_oe[0],    1'b0);
    check_val("rd_nrv",     n_rv,         1);
    check_val("rd_rout",    mon_rout[0],  8'hAA);
    check_val("rd_rvdly",   mon_rvdly[0], 1);

    // mem write 0x8056, slot 1
    wbuf[0] = 8'hBB;
    do_frame(8'h48, 16'h8056, 8'h00, 1);
    check_val("wr_nstrobe", n_strobe,    1);
    check_val("wr_is_wr",   mon_wr[0],   1'b1);
    check_val("wr_addr",    mon_addr[0], 16'h8056);
    check_val("wr_do",      mon_do[0],   8'hBB);
    check_val("wr_oe",      mon_oe[0],   1'b1);
    check_val("wr_len",     mon_len[0],  6);
    check_val("wr_sltsl",   mon_sl[0],   2'b01);
    check_val("wr_nrv",     n_rv,        0);

    // burst mem read across the 0xFFFF wrap
    DATA_I = 8'h5C;
    do_frame(8'h04, 16'hFFFE, 8'd4, NB4);
    check_val("brd_nstrobe", n_strobe,    NB4);
    check_val("brd_nrv",     n_rv,        NB4);
    check_val("brd_addr0",   mon_addr[0], 16'hFFFE);
    check_val("brd_rout0",   mon_rout[0], 8'h5C);
`ifdef MSXBUS_BURST_EN
    check_val("brd_addr1",   mon_addr[1], 16'hFFFF);
    check_val("brd_addr2",   mon_addr[2], 16'h0000);
    check_val("brd_addr3",   mon_addr[3], 16'h0001);
    check_val("brd_period",  mon_start[1] - mon_start[0], 10);
    check_val("brd_rvdly3",  mon_rvdly[3], 1);
`endif

    // I/O write burst at port 0x98
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_frame(8'hC4, 16'h0098, 8'd3, NB3);
    check_val("iow_nstrobe", n_strobe,    NB3);
    check_val("iow_iorq",    mon_iorq[0], 1'b0);
    check_val("iow_mreq",    mon_mreq[0], 1'b1);
    check_val("iow_sltsl",   mon_sl[0],   2'b11);
    check_val("iow_addr0",   mon_addr[0], 16'h0098);
    check_val("iow_do0",     mon_do[0],   8'h11);
`ifdef MSXBUS_BURST_EN
    check_val("iow_addr1",   mon_addr[1], 16'h0099);
    check_val("iow_addr2",   mon_addr[2], 16'h009A);
    check_val("iow_do2",     mon_do[2],   8'h33);
`endif

    // I/O burst wrapping the low address byte only
    wbuf[0] = 8'h44; wbuf[1] = 8'h55;
    do_frame(8'hC4, 16'h12FF, 8'd2, NB2);
    check_val("iowrap_nstrobe", n_strobe,    NB2);
    check_val("iowrap_addr0",   mon_addr[0], 16'h12FF);
`ifdef MSXBUS_BURST_EN
    check_val("iowrap_addr1",   mon_addr[1], 16'h1200);
    check_val("iowrap_do1",     mon_do[1],   8'h55);
`endif

    // open-bus read, slot 5
    DATA_I = 8'h3C;
    do_frame(8'h28, 16'h0001, 8'h00, 1);
    check_val("open_sltsl", mon_sl[0],   2'b11);
    check_val("open_mreq",  mon_mreq[0], 1'b0);
    check_val("open_nrv",   n_rv,        1);
    check_val("open_rout",  mon_rout[0], 8'h3C);

    // WAIT held, released in strobe cycle 10: strobe lasts 12 cycles through the synchroniser
    WAIT_n = 1'b0;
    DATA_I = 8'h77;
    mon_clear();
    CS = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h50);
    wait_strobe_low("wstretch_strobe");
    repeat (9) tick();
    WAIT_n = 1'b1;
    wait_idle("wstretch_idle");
    CS = 1'b1;
    tick();
    $display("[TB] wait-stretch read strobes=%0d len=%0d rvalids=%0d", n_strobe, mon_len[0], n_rv);
    check_val("wstretch_len",  mon_len[0],  12);
    check_val("wstretch_nrv",  n_rv,        1);
    check_val("wstretch_rout", mon_rout[0], 8'h77);
    check_val("wstretch_err",  ERR,         1'b0);

    // WAIT stuck low: timeout after WAIT_MAX extension cycles
    WAIT_n = 1'b0;
    do_frame(8'h00, 16'h6000, 8'h00, 1);
    check_val("tmo_len",    mon_len[0], 6 + 1023);
    check_val("tmo_nrv",    n_rv,       0);
    check_val("tmo_err",    ERR,        1'b1);
    check_val("tmo_rd_n",   RD_n,       1'b1);
    check_val("tmo_mreq_n", MREQ_n,     1'b1);
    WAIT_n = 1'b1;
    CS = 1'b0;
    send_byte(8'h00);
    check_val("errclr_err",  ERR,  1'b0);
    check_val("errclr_busy", BUSY, 1'b1);
    send_byte(8'h00);
    send_byte(8'h70);
    wait_idle("errclr_idle");
    CS = 1'b1;
    tick();
    $display("[TB] err-clear frame err=%0b", ERR);

    // CS raised in strobe cycle 3 of a write burst
    mon_clear();
    CS = 1'b0;
    send_byte(8'h44);
    send_byte(8'h00);
    send_byte(8'h20);
`ifdef MSXBUS_BURST_EN
    send_byte(8'd4);
`endif
    send_byte(8'hA1);
    wait_strobe_low("csab_strobe");
    tick();
    tick();
    CS = 1'b1;
    tick();
    tick();
    check_val("csab_wr_n",   WR_n,    1'b1);
    check_val("csab_mreq_n", MREQ_n,  1'b1);
    check_val("csab_oe",     DATA_OE, 1'b0);
    check_val("csab_busy",   BUSY,    1'b1);
    begin
      int n = 0;
      while (BUSY && n < 6) begin
        tick();
        n++;
      end
    end
    check_val("csab_idle",    BUSY,       1'b0);
    repeat (20) tick();
    check_val("csab_nstrobe", n_strobe,   1);
    check_val("csab_len",     mon_len[0], 4);
    check_val("csab_err",     ERR,        1'b0);
    $display("[TB] cs-abort write strobes=%0d len=%0d busy=%0b", n_strobe, mon_len[0], BUSY);

    // reset in the middle of a write strobe
    mon_clear();
    CS = 1'b0;
    send_byte(8'h48);
    send_byte(8'h00);
    send_byte(8'h90);
    send_byte(8'hC3);
    wait_strobe_low("rstmid_strobe");
    tick();
    RST = 1'b1;
    tick();
    check_val("rstmid_wr_n",   WR_n,    1'b1);
    check_val("rstmid_mreq_n", MREQ_n,  1'b1);
    check_val("rstmid_sltsl",  SLTSL_n, 2'b11);
    check_val("rstmid_oe",     DATA_OE, 1'b0);
    check_val("rstmid_do",     DATA_O,  8'h00);
    check_val("rstmid_addr",   ADDR,    16'h0000);
    check_val("rstmid_rout",   ROUT,    8'h00);
    check_val("rstmid_busy",   BUSY,    1'b0);
    RST = 1'b0;
    CS = 1'b1;
    tick();
    $display("[TB] reset mid-frame busy=%0b addr=%04h", BUSY, ADDR);

    // normal read after reset
    DATA_I = 8'h5A;
    do_frame(8'h00, 16'h1234, 8'h00, 1);
    check_val("post_addr", mon_addr[0], 16'h1234);
    check_val("post_nrv",  n_rv,        1);
    check_val("post_rout", mon_rout[0], 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msxbus_burst_bridge.md
# msxbus_burst_bridge

Parametrised successor to the single-transfer MSX bus bridge. It accepts a byte-serial command stream from the host side (CS-framed, byte-strobed) and executes memory or I/O cycles on the MSX cartridge bus. New over the single-transfer bridge: N slot selects, burst transfers with address auto-increment, programmable strobe timing, a WAIT timeout with error flag, and a separate host read-back channel. It sits between the host byte interface and the MSX bus pin drivers.

## Interface
- SLOTS, 2: number of SLTSL_n outputs (1..8)
- T_SETUP, 2: CLK cycles of address/select setup before the strobe (>=1)
- T_STROBE, 6: minimum CLK cycles the RD_n/WR_n strobe is asserted (>=2)
- T_RECOVER, 2: CLK cycles of idle bus after the strobe (>=1)
- WAIT_MAX, 1023: maximum CLK cycles the strobe is extended by WAIT_n; counter width is $clog2(WAIT_MAX+1)
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- CS  in  1  active-low host frame select
- HSTB  in  1  qualifies HDATA for one cycle
- HDATA  in  8  host command/address/data byte
- ROUT  out  8  read-back byte to host
- RVALID  out  1  one-cycle pulse, ROUT valid
- BUSY  out  1  high from command byte accepted until return to IDLE
- ERR  out  1  sticky WAIT-timeout flag; cleared by the next command byte
- WAIT_n  in  1  MSX WAIT, active low
- DATA_I  in  8  MSX data bus input
- DATA_O  out  8  MSX data bus output
- DATA_OE  out  1  drive enable for DATA_O
- ADDR  out  16  MSX address
- RD_n, WR_n, MREQ_n, IORQ_n  out  1 each  MSX strobes, active low
- SLTSL_n  out  SLOTS  slot selects, active low, one-hot-low

## Operation
- Command byte: [7:6] op (00 mem rd, 01 mem wr, 10 io rd, 11 io wr); [5:3] slot; [2] burst; [1:0] reserved, ignored. Slot >= SLOTS: no SLTSL_n asserted, cycle still runs (open-bus access).
- Frame: CMD, ADDR_L, ADDR_H, then LEN if burst (0 means 256, else 1..255), then for writes one data byte per beat. Non-burst = 1 beat.
- States: IDLE -> HDR_L -> HDR_H -> [LEN] -> (write: WDATA) -> SETUP -> STROBE -> RECOVER -> next beat (WDATA or SETUP) or IDLE.
- Only HSTB cycles with CS low advance the header/WDATA states; header bytes arriving while the bus is busy are not possible, since bytes are only consumed in HDR/LEN/WDATA.
- SETUP: ADDR, MREQ_n/IORQ_n, SLTSL_n (mem only; IORQ never asserts SLTSL_n), DATA_OE (writes) asserted; T_SETUP cycles.
- STROBE: RD_n or WR_n low. Ends after T_STROBE cycles once WAIT_n is sampled high; each cycle with WAIT_n low past the minimum increments the wait counter. Counter reaching WAIT_MAX: set ERR, abort the remaining beats, go to RECOVER then IDLE; no RVALID for the aborted beat.
- Read: DATA_I registered on the last STROBE cycle; ROUT/RVALID presented the following cycle.
- RECOVER: all strobes, selects and DATA_OE released; ADDR holds. Burst: ADDR increments by 1 per beat, wrapping 0xFFFF -> 0x0000; I/O bursts increment only ADDR[7:0], ADDR[15:8] held.
- CS high in any state other than IDLE: abort; if in SETUP/STROBE, release strobes next cycle and pass through RECOVER; then IDLE. ERR unchanged.
- RST: all outputs to idle regardless of state.

## Timing
- Reset values: RD_n, WR_n, MREQ_n, IORQ_n = 1; SLTSL_n = all ones; DATA_OE = 0; DATA_O = 0; ADDR = 0; ROUT = 0; RVALID = 0; BUSY = 0; ERR = 0.
- Last header byte (HSTB) to MREQ_n/IORQ_n low: 1 cycle. MREQ_n low to RD_n/WR_n low: T_SETUP cycles.
- Beat period with WAIT_n high: T_SETUP + T_STROBE + T_RECOVER cycles (defaults 10 = 200 ns at 50 MHz).
- RVALID: 1 cycle after RD_n rises. Write-burst beat waits in WDATA with all strobes released until HSTB.
- CS and HSTB are registered synchronous inputs; WAIT_n passes through a 2-flop synchroniser (2 cycles added latency on WAIT release).

## Configuration
- MSXBUS_BURST_EN defined: burst flag and LEN byte honoured as above.
- Undefined: command bit [2] ignored, no LEN byte, every frame is one beat; address auto-increment logic removed.

## Test plan
- Mem read 0x4034 slot 0, WAIT_n high, DATA_I=0xAA -> MREQ_n, SLTSL_n[0], RD_n low for 6 cycles; ROUT=0xAA, one RVALID pulse.
- Mem write 0x8056 slot 1, data 0xBB -> ADDR=0x8056, DATA_O=0xBB, DATA_OE high, WR_n low 6 cycles, SLTSL_n=2'b01.
- Burst mem read at 0xFFFE, LEN=4 -> ADDR 0xFFFE, 0xFFFF, 0x0000, 0x0001; exactly 4 RVALID pulses (MSXBUS_BURST_EN defined); with macro undefined, 1 beat.
- I/O write port 0x98, burst LEN=3 -> IORQ_n low, SLTSL_n all high, ADDR[7:0] 0x98, 0x99, 0x9A.
- Mem read with WAIT_n held low -> ERR set after WAIT_MAX extension cycles, no RVALID, bus idle; next command byte clears ERR.
- CS raised mid-STROBE of a 4-beat write -> strobes released next cycle, BUSY low after RECOVER; RST mid-frame -> all outputs at reset values next cycle.
